// File: rtl/tile_sprite_renderer_pkg.sv
// Shared constants for the tile/sprite renderer: game states, colours, default glyph masks.
package tile_sprite_renderer_pkg;

    localparam logic [2:0] GAME_STATE_IDLE    = 3'd0;
    localparam logic [2:0] GAME_STATE_PLAYING = 3'd1;
    localparam logic [2:0] GAME_STATE_DYING   = 3'd2;
    localparam logic [2:0] GAME_STATE_WIN     = 3'd3;
    localparam logic [2:0] GAME_STATE_OVER    = 3'd4;

    localparam logic [11:0] COLOR_BG    = 12'h000;
    localparam logic [11:0] COLOR_WALL  = 12'h00F;
    localparam logic [11:0] COLOR_DOT   = 12'hFFF;
    localparam logic [11:0] COLOR_DEBUG = 12'h74F;

    localparam int unsigned MASK_SIZE = 20;
    localparam int unsigned MASK_BITS = MASK_SIZE * MASK_SIZE;
    localparam int unsigned MASK_AW   = $clog2(MASK_BITS);

    // Square glyph lit on rows/cols lo..hi inclusive; bit index = row*MASK_SIZE+col.
    function automatic logic [MASK_BITS-1:0] square_mask(input int unsigned lo,
                                                         input int unsigned hi);
        logic [MASK_BITS-1:0] m;
        m = '0;
        for (int unsigned rr = 0; rr < MASK_SIZE; rr++) begin
            for (int unsigned cc = 0; cc < MASK_SIZE; cc++) begin
                if (rr >= lo && rr <= hi && cc >= lo && cc <= hi) begin
                    m[MASK_AW'(rr * MASK_SIZE + cc)] = 1'b1;
                end
            end
        end
        return m;
    endfunction

    localparam logic [MASK_BITS-1:0] DOT_MASK     = square_mask(8, 11);
    localparam logic [MASK_BITS-1:0] BIG_DOT_MASK = square_mask(5, 14);
    localparam logic [MASK_BITS-1:0] PLAYER_MASK  = square_mask(0, 19);
    localparam logic [MASK_BITS-1:0] GHOST_MASK   = square_mask(0, 19);

endpackage

// File: rtl/tile_sprite_renderer_mask_rom.sv
// Square bit ROM, asynchronous read by (row, col); out-of-range offsets read as unlit.
module tile_mask_rom #(
    parameter int unsigned         SIZE = 20,
    parameter int unsigned         W    = 5,
    parameter logic [SIZE*SIZE-1:0] MASK = '0
) (
    input  logic [W-1:0] row,
    input  logic [W-1:0] col,
    output logic         lit
);
    localparam int unsigned AW     = $clog2(SIZE * SIZE);
    localparam logic [W-1:0] SIZE_W = W'(SIZE);

    logic [AW-1:0] addr;

    // Row-major lookup with range guard.
    always_comb begin
        addr = AW'(row) * AW'(SIZE) + AW'(col);
        lit  = 1'b0;
        if (row < SIZE_W && col < SIZE_W) begin
            lit = MASK[addr];
        end
    end
endmodule

// File: rtl/tile_sprite_renderer.sv
// Three-stage per-pixel colour generator: maze tiles plus frame-latched sprites.
module tile_sprite_renderer
    import tile_sprite_renderer_pkg::*;
#(
    parameter int unsigned TILE_SIZE   = 20,
    parameter int unsigned TILE_W      = 5,
    parameter int unsigned COLS        = 32,
    parameter int unsigned ROWS        = 24,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 10,
    parameter int unsigned NUM_SPRITES = 5,
    parameter logic [TILE_SIZE*TILE_SIZE-1:0] DOT_BITS    = DOT_MASK,
    parameter logic [TILE_SIZE*TILE_SIZE-1:0] BIG_BITS    = BIG_DOT_MASK,
    parameter logic [TILE_SIZE*TILE_SIZE-1:0] PLAYER_BITS = PLAYER_MASK,
    parameter logic [TILE_SIZE*TILE_SIZE-1:0] GHOST_BITS  = GHOST_MASK
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pix_valid,
    input  logic [X_W-1:0]            pix_x,
    input  logic [Y_W-1:0]            pix_y,
    input  logic                      frame_start,
    input  logic [2:0]                game_state,
    input  logic [COLS*ROWS-1:0]      tile_walls,
    input  logic [COLS*ROWS-1:0]      tile_dots,
    input  logic [COLS*ROWS-1:0]      tile_big,
    input  logic [NUM_SPRITES*X_W-1:0] spr_x,
    input  logic [NUM_SPRITES*Y_W-1:0] spr_y,
    input  logic [NUM_SPRITES-1:0]    spr_en,
    input  logic [NUM_SPRITES*12-1:0] spr_rgb,
    output logic                      out_valid,
    output logic [3:0]                r,
    output logic [3:0]                g,
    output logic [3:0]                b
);
    localparam int unsigned IDX_W = $clog2(COLS * ROWS);

    // Frame-latched sprite state
    logic [NUM_SPRITES*X_W-1:0] sh_x;
    logic [NUM_SPRITES*Y_W-1:0] sh_y;
    logic [NUM_SPRITES-1:0]     sh_en;
    logic [NUM_SPRITES*12-1:0]  sh_rgb;

    // S1 combinational results and registers
    logic [X_W-1:0]    col_s;
    logic [Y_W-1:0]    row_s;
    logic [TILE_W-1:0] ox_s, oy_s;
    logic              oob_s;
    logic [NUM_SPRITES-1:0] hit_s;
    logic [TILE_W-1:0] lx_s [NUM_SPRITES];
    logic [TILE_W-1:0] ly_s [NUM_SPRITES];

    logic              v1, play1, oob1;
    logic [X_W-1:0]    col1;
    logic [Y_W-1:0]    row1;
    logic [TILE_W-1:0] ox1, oy1;
    logic [NUM_SPRITES-1:0] hit1;
    logic [TILE_W-1:0] lx1 [NUM_SPRITES];
    logic [TILE_W-1:0] ly1 [NUM_SPRITES];

    // S2 combinational results and registers
    logic [IDX_W-1:0]       idx;
    logic                   dot_lit, big_lit;
    logic [NUM_SPRITES-1:0] spr_lit;
    logic                   spr_any_s;
    logic [11:0]            spr_rgb_s;

    logic        v2, play2, oob2, wall2, dot2, big2, spr_any2;
    logic [11:0] spr_rgb2;
    logic [11:0] color_s;

    // Copy sprite inputs once per frame so a frame never mixes old and new positions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_x   <= '0;
            sh_y   <= '0;
            sh_en  <= '0;
            sh_rgb <= '0;
        end else if (frame_start) begin
            sh_x   <= spr_x;
            sh_y   <= spr_y;
            sh_en  <= spr_en;
            sh_rgb <= spr_rgb;
        end
    end

    // S1: tile coordinates and sprite bounding-box tests (one extra bit so nothing wraps).
    always_comb begin
        col_s = pix_x / X_W'(TILE_SIZE);
        row_s = pix_y / Y_W'(TILE_SIZE);
        ox_s  = TILE_W'(pix_x % X_W'(TILE_SIZE));
        oy_s  = TILE_W'(pix_y % Y_W'(TILE_SIZE));
        oob_s = (col_s >= X_W'(COLS)) || (row_s >= Y_W'(ROWS));
        for (int k = 0; k < int'(NUM_SPRITES); k++) begin
            hit_s[k] = sh_en[k]
                && ({1'b0, pix_x} >= {1'b0, sh_x[k*X_W +: X_W]})
                && ({1'b0, pix_x} < {1'b0, sh_x[k*X_W +: X_W]} + (X_W+1)'(TILE_SIZE))
                && ({1'b0, pix_y} >= {1'b0, sh_y[k*Y_W +: Y_W]})
                && ({1'b0, pix_y} < {1'b0, sh_y[k*Y_W +: Y_W]} + (Y_W+1)'(TILE_SIZE));
            lx_s[k] = TILE_W'(pix_x - sh_x[k*X_W +: X_W]);
            ly_s[k] = TILE_W'(pix_y - sh_y[k*Y_W +: Y_W]);
        end
    end

    // S1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            play1 <= 1'b0;
            oob1  <= 1'b0;
            col1  <= '0;
            row1  <= '0;
            ox1   <= '0;
            oy1   <= '0;
            hit1  <= '0;
            for (int k = 0; k < int'(NUM_SPRITES); k++) begin
                lx1[k] <= '0;
                ly1[k] <= '0;
            end
        end else begin
            v1    <= pix_valid;
            play1 <= (game_state == GAME_STATE_PLAYING);
            oob1  <= oob_s;
            col1  <= col_s;
            row1  <= row_s;
            ox1   <= ox_s;
            oy1   <= oy_s;
            hit1  <= hit_s;
            for (int k = 0; k < int'(NUM_SPRITES); k++) begin
                lx1[k] <= lx_s[k];
                ly1[k] <= ly_s[k];
            end
        end
    end

    tile_mask_rom #(.SIZE(TILE_SIZE), .W(TILE_W), .MASK(DOT_BITS)) u_dot_rom (
        .row(oy1), .col(ox1), .lit(dot_lit)
    );
    tile_mask_rom #(.SIZE(TILE_SIZE), .W(TILE_W), .MASK(BIG_BITS)) u_big_rom (
        .row(oy1), .col(ox1), .lit(big_lit)
    );

    for (genvar k = 0; k < int'(NUM_SPRITES); k++) begin : g_spr
        tile_mask_rom #(
            .SIZE(TILE_SIZE), .W(TILE_W), .MASK((k == 0) ? PLAYER_BITS : GHOST_BITS)
        ) u_spr_rom (
            .row(ly1[k]), .col(lx1[k]), .lit(spr_lit[k])
        );
    end

    // S2: bitmap lookups and sprite priority (descending scan so the lowest index wins).
    always_comb begin
        idx       = oob1 ? '0 : IDX_W'(row1) * IDX_W'(COLS) + IDX_W'(col1);
        spr_any_s = 1'b0;
        spr_rgb_s = COLOR_BG;
        for (int k = int'(NUM_SPRITES) - 1; k >= 0; k--) begin
            if (hit1[k] && spr_lit[k]) begin
                spr_any_s = 1'b1;
                spr_rgb_s = sh_rgb[k*12 +: 12];
            end
        end
    end

    // S2 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            play2    <= 1'b0;
            oob2     <= 1'b0;
            wall2    <= 1'b0;
            dot2     <= 1'b0;
            big2     <= 1'b0;
            spr_any2 <= 1'b0;
            spr_rgb2 <= '0;
        end else begin
            v2       <= v1;
            play2    <= play1;
            oob2     <= oob1;
            wall2    <= !oob1 && tile_walls[idx];
            dot2     <= !oob1 && tile_dots[idx] && dot_lit;
            big2     <= !oob1 && tile_big[idx] && big_lit;
            spr_any2 <= spr_any_s;
            spr_rgb2 <= spr_rgb_s;
        end
    end

    // S3: colour priority.
    always_comb begin
        color_s = COLOR_BG;
        if (!play2)        color_s = COLOR_DEBUG;
        else if (oob2)     color_s = COLOR_BG;
        else if (wall2)    color_s = COLOR_WALL;
        else if (spr_any2) color_s = spr_rgb2;
        else if (dot2)     color_s = COLOR_DOT;
        else if (big2)     color_s = COLOR_DOT;
    end

    // Output register; invalid pixels are forced black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            {r, g, b}   <= '0;
        end else begin
            out_valid   <= v2;
            {r, g, b}   <= v2 ? color_s : COLOR_BG;
        end
    end
endmodule

// File: tb/tb_tile_sprite_renderer.sv
// Directed bench for tile_sprite_renderer: latency, reset, priority, frame latch, edges.
module tb_tile_sprite_renderer;
    import tile_sprite_renderer_pkg::*;

    localparam int unsigned NS = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic [9:0]    pix_x = '0;
    logic [9:0]    pix_y = '0;
    logic          frame_start = 1'b0;
    logic [2:0]    game_state = GAME_STATE_PLAYING;
    logic [767:0]  tile_walls = '0;
    logic [767:0]  tile_dots = '0;
    logic [767:0]  tile_big = '0;
    logic [NS*10-1:0] spr_x = '0;
    logic [NS*10-1:0] spr_y = '0;
    logic [NS-1:0]    spr_en = '0;
    logic [NS*12-1:0] spr_rgb = '0;
    logic          out_valid;
    logic [3:0]    r, g, b;
    logic [15:0]   obs_w;

    int checks = 0;
    int failures = 0;

    tile_sprite_renderer dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .game_state(game_state), .tile_walls(tile_walls),
        .tile_dots(tile_dots), .tile_big(tile_big), .spr_x(spr_x), .spr_y(spr_y),
        .spr_en(spr_en), .spr_rgb(spr_rgb), .out_valid(out_valid), .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    assign obs_w = {3'b000, out_valid, r, g, b};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Hold one pixel for three clocks, then compare the output it produced.
    task automatic pixel(input string tag, input int x, input int y, input logic v,
                         input logic [15:0] exp);
        pix_valid = v;
        pix_x = 10'(x);
        pix_y = 10'(y);
        repeat (3) @(negedge clk);
        check(tag, obs_w, exp);
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        tile_walls[0] = 1'b1;   // tile (0,0)
        tile_dots[5]  = 1'b1;   // tile col 5, row 0
        tile_big[6]   = 1'b1;   // tile col 6, row 0

        // Reset state
        @(negedge clk);
        check("reset_idle", obs_w, 16'h0000);
        pix_valid = 1'b1;
        @(negedge clk);
        check("reset_hold", obs_w, 16'h0000);
        pix_valid = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("flushed", obs_w, 16'h0000);

        // Exact 3-cycle latency on a wall tile
        pix_valid = 1'b1; pix_x = 10'd0; pix_y = 10'd0;
        @(negedge clk); check("lat_c1", obs_w, 16'h0000);
        @(negedge clk); check("lat_c2", obs_w, 16'h0000);
        @(negedge clk); check("lat_c3", obs_w, 16'h100F);

        // Dots, big dots, out of bounds
        pixel("dot_lit",   110, 10, 1'b1, 16'h1FFF);
        pixel("dot_edge",  100, 10, 1'b1, 16'h1000);
        pixel("big_lit",   125, 10, 1'b1, 16'h1FFF);
        pixel("big_edge",  121, 10, 1'b1, 16'h1000);
        pixel("oob_x",     640, 10, 1'b1, 16'h1000);
        pixel("oob_y",      10, 480, 1'b1, 16'h1000);

        // Overlapping sprites: lowest index wins
        spr_x[0 +: 10] = 10'd40;  spr_y[0 +: 10] = 10'd40;
        spr_x[10 +: 10] = 10'd40; spr_y[10 +: 10] = 10'd40;
        spr_rgb[0 +: 12] = 12'hFF0; spr_rgb[12 +: 12] = 12'hF00;
        spr_en = 5'b00011;
        frame_pulse();
        pixel("overlap_p0", 45, 45, 1'b1, 16'h1FF0);
        spr_en = 5'b00010;
        frame_pulse();
        pixel("overlap_p1", 45, 45, 1'b1, 16'h1F00);

        // Frame latching of sprite position
        spr_en = 5'b00001;
        frame_pulse();
        pixel("latch_base", 45, 45, 1'b1, 16'h1FF0);
        spr_x[0 +: 10] = 10'd100;
        pixel("latch_hold", 45, 45, 1'b1, 16'h1FF0);
        frame_pulse();
        pixel("latch_new",  45, 45, 1'b1, 16'h1000);
        pixel("latch_moved", 105, 45, 1'b1, 16'h1FF0);

        // Right-edge sprite must not wrap to x=0
        spr_x[0 +: 10] = 10'd630;
        frame_pulse();
        pixel("edge_nowrap", 5, 45, 1'b1, 16'h1000);
        pixel("edge_hit",  639, 45, 1'b1, 16'h1FF0);
        pixel("edge_left", 629, 45, 1'b1, 16'h1000);

        // Non-playing state
        game_state = GAME_STATE_IDLE;
        pixel("state_dbg",  45, 45, 1'b1, 16'h174F);
        pixel("state_inv",  45, 45, 1'b0, 16'h0000);
        game_state = GAME_STATE_PLAYING;

        // Mid-stream asynchronous reset
        pixel("pre_reset", 0, 0, 1'b1, 16'h100F);
        #1 rst_n = 1'b0;
        #1 check("rst_async", obs_w, 16'h0000);
        @(negedge clk);
        check("rst_held", obs_w, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk); check("rst_c1", obs_w, 16'h0000);
        @(negedge clk); check("rst_c2", obs_w, 16'h0000);
        @(negedge clk); check("rst_c3", obs_w, 16'h100F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
